// File: rtl/radar_pkg.sv
// Shared constants for the radar display path: FSM encodings, segment
// patterns and the double-dabble nibble correction.
package radar_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_LOAD = 2'd2;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Active-low patterns for digits 0..9, bit0 = segment a.
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
    return (nib >= 4'd5) ? (nib + 4'd3) : nib;
  endfunction

endpackage

// File: rtl/seg7_digit_enc.sv
// One BCD digit to active-low seven-segment pattern; dash wins over blank,
// non-decimal nibbles show blank.
module seg7_digit_enc
  import radar_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  // Pattern select
  always_comb begin
    seg = SEG_BLANK;
    if (dash) begin
      seg = SEG_DASH;
    end else if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (nibble)
        4'd0:    seg = SEG_DIGIT[0];
        4'd1:    seg = SEG_DIGIT[1];
        4'd2:    seg = SEG_DIGIT[2];
        4'd3:    seg = SEG_DIGIT[3];
        4'd4:    seg = SEG_DIGIT[4];
        4'd5:    seg = SEG_DIGIT[5];
        4'd6:    seg = SEG_DIGIT[6];
        4'd7:    seg = SEG_DIGIT[7];
        4'd8:    seg = SEG_DIGIT[8];
        4'd9:    seg = SEG_DIGIT[9];
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/distance_display_ctrl.sv
// Captures 10-bit distance words, converts them to BCD one bit per clock
// and drives four active-low digits with blanking and out-of-range dashes.
module distance_display_ctrl
  import radar_pkg::*;
#(
  parameter int MAX_CM   = 400,
  parameter int BLANK_LZ = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] distance,
  input  logic       distance_valid,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic [6:0] hex4,
  output logic [6:0] hex5,
  output logic [15:0] bcd,
  output logic       out_of_range,
  output logic       busy,
  output logic       done
);

  localparam logic [10:0] MAX_W    = 11'(MAX_CM);
  localparam logic        BLANK_EN = (BLANK_LZ != 0);

  logic [1:0]  state_q, state_d;
  logic [3:0]  iter_q, iter_d;
  logic [9:0]  bin_q, bin_d;
  logic [15:0] work_q, work_d;
  logic [9:0]  cap_q, cap_d;
  logic        pend_flag_q, pend_flag_d;
  logic [9:0]  pend_val_q, pend_val_d;
  logic [15:0] bcd_q, bcd_d;
  logic        oor_q, oor_d;
  logic [6:0]  hex0_q, hex0_d, hex1_q, hex1_d, hex2_q, hex2_d, hex3_q, hex3_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [15:0] adj_s;
  logic        oor_s;
  logic        lz3_s, lz2_s, lz1_s;
  logic [6:0]  seg0_s, seg1_s, seg2_s, seg3_s;

  assign adj_s = {dd_adjust(work_q[15:12]), dd_adjust(work_q[11:8]),
                  dd_adjust(work_q[7:4]),   dd_adjust(work_q[3:0])};
  assign oor_s = ({1'b0, cap_q} > MAX_W);

  // A digit blanks only when it and every digit above it are zero.
  assign lz3_s = BLANK_EN && (work_q[15:12] == 4'd0);
  assign lz2_s = lz3_s && (work_q[11:8] == 4'd0);
  assign lz1_s = lz2_s && (work_q[7:4] == 4'd0);

  seg7_digit_enc u_enc0 (.nibble(work_q[3:0]),   .blank(1'b0),  .dash(oor_s), .seg(seg0_s));
  seg7_digit_enc u_enc1 (.nibble(work_q[7:4]),   .blank(lz1_s), .dash(oor_s), .seg(seg1_s));
  seg7_digit_enc u_enc2 (.nibble(work_q[11:8]),  .blank(lz2_s), .dash(oor_s), .seg(seg2_s));
  seg7_digit_enc u_enc3 (.nibble(work_q[15:12]), .blank(lz3_s), .dash(oor_s), .seg(seg3_s));

  // Next-state: capture, shift-add-3 conversion, display load, pending strobe
  always_comb begin
    state_d     = state_q;
    iter_d      = iter_q;
    bin_d       = bin_q;
    work_d      = work_q;
    cap_d       = cap_q;
    pend_flag_d = pend_flag_q;
    pend_val_d  = pend_val_q;
    bcd_d       = bcd_q;
    oor_d       = oor_q;
    hex0_d      = hex0_q;
    hex1_d      = hex1_q;
    hex2_d      = hex2_q;
    hex3_d      = hex3_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (distance_valid) begin
          cap_d   = distance;
          bin_d   = distance;
          work_d  = 16'd0;
          iter_d  = 4'd0;
          state_d = ST_CONV;
        end else if (pend_flag_q) begin
          cap_d       = pend_val_q;
          bin_d       = pend_val_q;
          work_d      = 16'd0;
          iter_d      = 4'd0;
          pend_flag_d = 1'b0;
          state_d     = ST_CONV;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CONV: begin
        work_d = {adj_s[14:0], bin_q[9]};
        bin_d  = {bin_q[8:0], 1'b0};
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'd9) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_CONV;
        end
      end
      ST_LOAD: begin
        bcd_d   = work_q;
        oor_d   = oor_s;
        hex0_d  = seg0_s;
        hex1_d  = seg1_s;
        hex2_d  = seg2_s;
        hex3_d  = seg3_s;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Strobes arriving mid-conversion keep only the newest value.
    if (distance_valid && (state_q != ST_IDLE)) begin
      pend_val_d  = distance;
      pend_flag_d = 1'b1;
    end else begin
      pend_val_d = pend_val_q;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      iter_q      <= 4'd0;
      bin_q       <= 10'd0;
      work_q      <= 16'd0;
      cap_q       <= 10'd0;
      pend_flag_q <= 1'b0;
      pend_val_q  <= 10'd0;
      bcd_q       <= 16'd0;
      oor_q       <= 1'b0;
      hex0_q      <= SEG_BLANK;
      hex1_q      <= SEG_BLANK;
      hex2_q      <= SEG_BLANK;
      hex3_q      <= SEG_BLANK;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      iter_q      <= iter_d;
      bin_q       <= bin_d;
      work_q      <= work_d;
      cap_q       <= cap_d;
      pend_flag_q <= pend_flag_d;
      pend_val_q  <= pend_val_d;
      bcd_q       <= bcd_d;
      oor_q       <= oor_d;
      hex0_q      <= hex0_d;
      hex1_q      <= hex1_d;
      hex2_q      <= hex2_d;
      hex3_q      <= hex3_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign hex0         = hex0_q;
  assign hex1         = hex1_q;
  assign hex2         = hex2_q;
  assign hex3         = hex3_q;
  assign hex4         = SEG_BLANK;
  assign hex5         = SEG_BLANK;
  assign bcd          = bcd_q;
  assign out_of_range = oor_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
